// File: rtl/alu_ctrl_pipe_pkg.sv
// Shared constants, FSM state type and the ALU control-word decode rules
// for the registered ALU control stage.
package alu_ctrl_pkg;

    localparam logic [2:0] ALUOP_RTYPE  = 3'b000;
    localparam logic [2:0] ALUOP_ITYPE  = 3'b001;
    localparam logic [2:0] ALUOP_BRANCH = 3'b010;
    localparam logic [2:0] ALUOP_JUMP   = 3'b011;

    localparam logic [2:0] GRP_BASE   = 3'b000;
    localparam logic [2:0] GRP_ALT    = 3'b001;
    localparam logic [2:0] GRP_BRANCH = 3'b010;
    localparam logic [2:0] GRP_JUMP   = 3'b011;
    localparam logic [2:0] GRP_MDU    = 3'b100;

    localparam int BASE_CTRL_W = 6;

    typedef enum logic {IDLE, BUSY} state_t;

    // f7[0] = funct7[5] (sub/sra), f7[1] = funct7[0] (M extension)
    function automatic logic [BASE_CTRL_W-1:0] decode_ctrl(input logic [2:0] alu_op,
                                                           input logic [2:0] f3,
                                                           input logic [1:0] f7);
        logic [BASE_CTRL_W-1:0] c;
        c = '0;
        case (alu_op)
            ALUOP_JUMP:   c = {GRP_JUMP, 3'b111};
            ALUOP_BRANCH: c = {GRP_BRANCH, f3};
            ALUOP_RTYPE: begin
                if (f7[1])      c = {GRP_MDU, f3};
                else if (f7[0]) c = {GRP_ALT, f3};
                else            c = {GRP_BASE, f3};
            end
            ALUOP_ITYPE: begin
                if (f3 == 3'b101 && f7[0]) c = {GRP_ALT, 3'b101};
                else                       c = {GRP_BASE, f3};
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic is_mdu_op(input logic [2:0] alu_op, input logic [1:0] f7);
        return (alu_op == ALUOP_RTYPE) && f7[1];
    endfunction

endpackage

// File: rtl/alu_ctrl_pipe_if.sv
// Decode-to-execute handshake bundle for alu_ctrl_pipe; slave is the block's view.
interface alu_ctrl_pipe_if #(
    parameter int CTRL_W = 6
);
    logic              flush_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [2:0]        alu_op_i;
    logic [2:0]        func3_i;
    logic [1:0]        func7_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [CTRL_W-1:0] alu_ctrl_o;
    logic              mdu_busy_o;
    logic              illegal_o;

    modport slave (
        input  flush_i, in_valid_i, alu_op_i, func3_i, func7_i, out_ready_i,
        output in_ready_o, out_valid_o, alu_ctrl_o, mdu_busy_o, illegal_o
    );

    modport master (
        output flush_i, in_valid_i, alu_op_i, func3_i, func7_i, out_ready_i,
        input  in_ready_o, out_valid_o, alu_ctrl_o, mdu_busy_o, illegal_o
    );
endinterface

// File: rtl/alu_ctrl_pipe_decode.sv
// Pure combinational ALU control decode; flags M-extension ops for the pipe.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
(
    input  logic [2:0]             alu_op_i,
    input  logic [2:0]             func3_i,
    input  logic [1:0]             func7_i,
    output logic [BASE_CTRL_W-1:0] ctrl_o,
    output logic                   mdu_o
);
    assign ctrl_o = decode_ctrl(alu_op_i, func3_i, func7_i);
    assign mdu_o  = is_mdu_op(alu_op_i, func7_i);
endmodule

// File: rtl/alu_ctrl_pipe.sv
// Registered ALU control stage with valid/ready on both sides.
// Define ALU_CTRL_MDU_EN to build the multi-cycle hold for multiply/divide ops.
module alu_ctrl_pipe
    import alu_ctrl_pkg::*;
#(
    parameter int CTRL_W  = 6,
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 32
) (
    input  logic          clk,
    input  logic          reset,
    alu_ctrl_pipe_if.slave bus
);
    if (CTRL_W < BASE_CTRL_W) begin : g_bad_w
        $error("CTRL_W must be >= 6");
    end
    if (MUL_LAT < 1 || DIV_LAT < 1) begin : g_bad_lat
        $error("MUL_LAT and DIV_LAT must be >= 1");
    end

    logic [BASE_CTRL_W-1:0] dec_ctrl;
    logic                   dec_mdu;
    logic                   out_valid_q;
    logic                   illegal_q;
    logic [CTRL_W-1:0]      ctrl_q;
    logic                   idle;
    logic                   mdu_busy;
    logic                   accept;
    logic                   drain;

    alu_ctrl_decode u_dec (
        .alu_op_i (bus.alu_op_i),
        .func3_i  (bus.func3_i),
        .func7_i  (bus.func7_i),
        .ctrl_o   (dec_ctrl),
        .mdu_o    (dec_mdu)
    );

    assign drain          = out_valid_q & bus.out_ready_i;
    assign bus.in_ready_o = idle & (~out_valid_q | bus.out_ready_i) & ~bus.flush_i & ~reset;
    assign accept         = bus.in_valid_i & bus.in_ready_o;

`ifdef ALU_CTRL_MDU_EN
    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            ctrl_q      <= '0;
            illegal_q   <= 1'b0;
        end else if (bus.flush_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        ctrl_q    <= CTRL_W'(dec_ctrl);
                        illegal_q <= 1'b0;
                        if (dec_mdu) begin
                            // func3[2] separates div/rem from the multiply group
                            state_q     <= BUSY;
                            cnt_q       <= bus.func3_i[2] ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
                            busy_q      <= 1'b1;
                            out_valid_q <= 1'b0;
                        end else begin
                            out_valid_q <= 1'b1;
                        end
                    end else if (drain) begin
                        out_valid_q <= 1'b0;
                    end
                end
                BUSY: begin
                    if (cnt_q == '0) begin
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign idle     = (state_q == IDLE);
    assign mdu_busy = busy_q;
`else
    // Without the MDU, M ops complete at once as an illegal op with a zero control word.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            ctrl_q      <= '0;
            illegal_q   <= 1'b0;
        end else if (bus.flush_i) begin
            out_valid_q <= 1'b0;
        end else if (accept) begin
            ctrl_q      <= dec_mdu ? '0 : CTRL_W'(dec_ctrl);
            illegal_q   <= dec_mdu;
            out_valid_q <= 1'b1;
        end else if (drain) begin
            out_valid_q <= 1'b0;
        end
    end

    assign idle     = 1'b1;
    assign mdu_busy = 1'b0;
`endif

    assign bus.out_valid_o = out_valid_q;
    assign bus.alu_ctrl_o  = ctrl_q;
    assign bus.illegal_o   = illegal_q;
    assign bus.mdu_busy_o  = mdu_busy;

endmodule
